// File: rtl/regfile_mp_clr.sv
// Register file: two combinational read ports, one write port, and one registered debug read port.
// Clears one entry per cycle after reset or i_clr. REGFILE_WR_BYPASS_EN enables write-to-read forwarding.
module regfile_mp_clr #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rd2_addr,
    input  logic                  i_dbg_req,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    output logic [DATA_WIDTH-1:0] o_rd1_data,
    output logic [DATA_WIDTH-1:0] o_rd2_data,
    output logic [DATA_WIDTH-1:0] o_dbg_data,
    output logic                  o_dbg_valid,
    output logic                  o_busy
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
    logic [DATA_WIDTH-1:0]   dbg_data_reg;
    logic                    dbg_valid_reg;
    logic [DATA_WIDTH-1:0]   mem [NUM_REGS];

    logic                    idle;
    logic                    wr_ok;
    logic [ADDR_WIDTH-1:0]   port_addr [3];
    logic [DATA_WIDTH-1:0]   array_word [3];
    logic [DATA_WIDTH-1:0]   rd_data [2];
    logic [1:0]              bypass_hit;

    assign idle  = (state_reg == IDLE);
    assign wr_ok = idle && !i_rst && !i_clr && i_wr_en &&
                   !((ZERO_REG != 0) && (i_wr_addr == '0));

    // Ports 0/1 are the ID-stage reads, port 2 is the debug read.
    assign port_addr[0] = i_rd1_addr;
    assign port_addr[1] = i_rd2_addr;
    assign port_addr[2] = i_dbg_addr;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_array_rd
            assign array_word[gi] = ((ZERO_REG != 0) && (port_addr[gi] == '0)) ?
                                    '0 : mem[port_addr[gi]];
        end

        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef REGFILE_WR_BYPASS_EN
            assign bypass_hit[gi] = idle && i_wr_en && (port_addr[gi] == i_wr_addr) &&
                                    !((ZERO_REG != 0) && (i_wr_addr == '0));
`else
            assign bypass_hit[gi] = 1'b0;
`endif
            assign rd_data[gi] = !idle         ? '0 :
                                 bypass_hit[gi] ? i_wr_data : array_word[gi];
        end
    endgenerate

    assign o_rd1_data  = rd_data[0];
    assign o_rd2_data  = rd_data[1];
    assign o_dbg_data  = dbg_data_reg;
    assign o_dbg_valid = dbg_valid_reg;
    assign o_busy      = (state_reg == CLEAR);

    // Array has a single write path: either the sweeping clear or the WB write.
    always_ff @(posedge i_clk) begin
        if (state_reg == CLEAR) begin
            mem[clr_cnt_reg] <= '0;
        end else if (wr_ok) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= CLEAR;
            clr_cnt_reg   <= '0;
            dbg_data_reg  <= '0;
            dbg_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    dbg_valid_reg <= i_dbg_req;
                    if (i_dbg_req) begin
                        dbg_data_reg <= array_word[2];
                    end
                    if (i_clr) begin
                        state_reg   <= CLEAR;
                        clr_cnt_reg <= '0;
                    end
                end
                CLEAR: begin
                    dbg_valid_reg <= 1'b0;
                    if (i_clr) begin
                        clr_cnt_reg <= '0;
                    end else if (clr_cnt_reg == ADDR_WIDTH'(NUM_REGS - 1)) begin
                        state_reg   <= IDLE;
                        clr_cnt_reg <= '0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= CLEAR;
                    clr_cnt_reg <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_mp_clr.sv
// Bench for regfile_mp_clr: directed steps then random traffic, checked each cycle against a
// behavioural model (array contents plus a count of remaining clear cycles).
module tb_regfile_mp_clr;
    localparam int N  = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, clr, wr_en, dbg_req;
    logic [AW-1:0] wr_addr, rd1_addr, rd2_addr, dbg_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd1_data, rd2_data, dbg_data;
    logic          dbg_valid, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mm [N];
    int            busy_left;
    logic [DW-1:0] m_dbg_data;
    logic          m_dbg_valid;

    always #5 clk = ~clk;

    regfile_mp_clr dut (
        .i_clk(clk), .i_rst(rst), .i_clr(clr),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd1_addr(rd1_addr), .i_rd2_addr(rd2_addr),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr),
        .o_rd1_data(rd1_data), .o_rd2_data(rd2_data),
        .o_dbg_data(dbg_data), .o_dbg_valid(dbg_valid), .o_busy(busy)
    );

    function automatic logic [DW-1:0] stored(input logic [AW-1:0] a);
        return (a == 0) ? '0 : mm[a];
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (busy_left > 0) return '0;
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_en && a == wr_addr && a != 0) return wr_data;
`endif
        return stored(a);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wipe();
        for (int i = 0; i < N; i++) mm[i] = '0;
    endtask

    // One clock: compare outputs mid-cycle, advance the model with the same inputs, take the edge.
    task automatic step();
        @(negedge clk);
        chk("rd1", rd1_data, exp_rd(rd1_addr));
        chk("rd2", rd2_data, exp_rd(rd2_addr));
        chk("busy", {31'b0, busy}, {31'b0, busy_left > 0});
        chk("dbg_valid", {31'b0, dbg_valid}, {31'b0, m_dbg_valid});
        chk("dbg_data", dbg_data, m_dbg_data);
        if (rst) begin
            busy_left = N; m_dbg_valid = 1'b0; m_dbg_data = '0; wipe();
        end else if (busy_left > 0) begin
            m_dbg_valid = 1'b0;
            busy_left = clr ? N : busy_left - 1;
        end else begin
            m_dbg_valid = dbg_req;
            if (dbg_req) m_dbg_data = stored(dbg_addr);
            if (clr) begin
                busy_left = N; wipe();
            end else if (wr_en && wr_addr != 0) begin
                mm[wr_addr] = wr_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quiet();
        rst = 0; clr = 0; wr_en = 0; dbg_req = 0;
    endtask

    initial begin
        rst = 1; clr = 0; wr_en = 0; dbg_req = 0;
        wr_addr = 0; wr_data = 0; rd1_addr = 5; rd2_addr = 31; dbg_addr = 0;
        // Power-up state is unknown until the first reset edge.
        @(posedge clk); #1;
        busy_left = N; m_dbg_valid = 1'b0; m_dbg_data = '0; wipe();
        rst = 0;

        // Step 1: reset sweep, busy for exactly N cycles.
        steps(N + 1);
        chk("busy_after_reset", {31'b0, busy}, 32'd0);

        // Step 2: write then read; zero register.
        wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; step();
        wr_en = 0; rd1_addr = 7; step();
        #1 chk("rd1_7", rd1_data, 32'hDEADBEEF);
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; step();
        wr_en = 0; rd2_addr = 0; step();
        #1 chk("rd2_0", rd2_data, 32'h0);

        // Step 3: write/read collision on address 9.
        wr_en = 1; wr_addr = 9; wr_data = 32'h11111111; step();
        wr_data = 32'hA5A5A5A5; rd1_addr = 9; step();
        wr_en = 0; step();
        #1 chk("rd1_9_next", rd1_data, 32'hA5A5A5A5);

        // Step 4: debug read and hold.
        dbg_req = 1; dbg_addr = 7; step();
        dbg_req = 0; dbg_addr = 9; steps(3);
        #1 chk("dbg_hold", dbg_data, 32'hDEADBEEF);

        // Step 5: clear, re-clear after 10 cycles, write dropped during busy.
        clr = 1; step();
        clr = 0; steps(4);
        wr_en = 1; wr_addr = 3; wr_data = 32'h55; step();
        wr_en = 0; steps(4);
        clr = 1; step();
        clr = 0; steps(N + 1);
        rd1_addr = 3; rd2_addr = 7; step();
        #1 chk("rd1_3_cleared", rd1_data, 32'h0);
        rd1_addr = 7; step();
        #1 chk("rd1_7_cleared", rd1_data, 32'h0);

        // Step 6: reset at clear cycle 20.
        clr = 1; step();
        clr = 0; steps(19);
        rst = 1; step();
        rst = 0; steps(N + 1);

        // Random traffic including occasional clear and reset.
        for (int i = 0; i < 600; i++) begin
            quiet();
            rst      = ($urandom_range(0, 199) == 0);
            clr      = ($urandom_range(0, 79) == 0);
            wr_en    = $urandom_range(0, 1);
            wr_addr  = AW'($urandom);
            wr_data  = $urandom;
            rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            rd2_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            dbg_req  = ($urandom_range(0, 3) == 0);
            dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            step();
        end
        quiet();
        steps(N + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
